// File: rtl/phase_sequencer.sv
// Timing and sequencing controller for the 8-phase intersection FSM, with emergency preemption.
// Optional left-turn demand sensing is compiled in with `define PHASE_SEQ_LEFT_SENSE_EN.
module phase_sequencer #(
    parameter int CLK_DIV  = 50_000_000,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 4,
    parameter int RED_T    = 2,
    parameter int LEFT_T   = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             emergency,
`ifdef PHASE_SEQ_LEFT_SENSE_EN
    input  logic             left_req_n,
    input  logic             left_req_e,
`endif
    output logic             go,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             emerg_active
);

    localparam int PW = $clog2(CLK_DIV);

    localparam logic [PW-1:0]    PRE_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] GREEN_L  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] RED_L    = CNT_W'(RED_T - 1);
    localparam logic [CNT_W-1:0] LEFT_L   = CNT_W'(LEFT_T - 1);

    typedef enum logic [1:0] {
        RUN,
        PREEMPT,
        HOLD
    } ctrl_t;

    ctrl_t            ctrl, ctrl_next;
    logic [PW-1:0]    presc, presc_next;
    logic [2:0]       phase_next;
    logic [CNT_W-1:0] remaining_next;
    logic             esync_meta, esync;
    logic             tick;
    logic             left_ok_n, left_ok_e;

    function automatic logic is_red(input logic [2:0] p);
        return (p == 3'd2) || (p == 3'd6);
    endfunction

    // Green and left phases are the ones an emergency may cut short.
    function automatic logic is_trunc(input logic [2:0] p);
        return (p == 3'd0) || (p == 3'd3) || (p == 3'd4) || (p == 3'd7);
    endfunction

    function automatic logic [CNT_W-1:0] entry_load(input logic [2:0] p, input logic preempt,
                                                    input logic ok_n, input logic ok_e);
        logic [CNT_W-1:0] v;
        case (p)
            3'd0, 3'd4: v = GREEN_L;
            3'd1, 3'd5: v = YELLOW_L;
            3'd2, 3'd6: v = RED_L;
            3'd3:       v = ok_e ? LEFT_L : '0;
            default:    v = ok_n ? LEFT_L : '0;
        endcase
        if (preempt && is_trunc(p)) begin
            v = '0;
        end
        return v;
    endfunction

`ifdef PHASE_SEQ_LEFT_SENSE_EN
    logic latch_n, latch_e;

    // Demand is remembered until its left phase has been served.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            latch_n <= 1'b0;
            latch_e <= 1'b0;
        end else begin
            if (left_req_n && (phase != 3'd7)) begin
                latch_n <= 1'b1;
            end else if (go && (phase == 3'd7)) begin
                latch_n <= 1'b0;
            end
            if (left_req_e && (phase != 3'd3)) begin
                latch_e <= 1'b1;
            end else if (go && (phase == 3'd3)) begin
                latch_e <= 1'b0;
            end
        end
    end

    assign left_ok_n = latch_n | left_req_n;
    assign left_ok_e = latch_e | left_req_e;
`else
    assign left_ok_n = 1'b1;
    assign left_ok_e = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl         <= RUN;
            presc        <= '0;
            phase        <= 3'd0;
            remaining    <= GREEN_L;
            esync_meta   <= 1'b0;
            esync        <= 1'b0;
            emerg_active <= 1'b0;
        end else begin
            ctrl         <= ctrl_next;
            presc        <= presc_next;
            phase        <= phase_next;
            remaining    <= remaining_next;
            esync_meta   <= emergency;
            esync        <= esync_meta;
            emerg_active <= (ctrl_next != RUN);
        end
    end

    always_comb begin
        ctrl_next      = ctrl;
        presc_next     = presc;
        phase_next     = phase;
        remaining_next = remaining;
        go             = 1'b0;
        tick           = enable && (ctrl != HOLD) && (presc == PRE_MAX);

        if (enable) begin
            if ((ctrl == HOLD) || tick) begin
                presc_next = '0;
            end else begin
                presc_next = presc + PRE_ONE;
            end

            if (tick) begin
                if (remaining != '0) begin
                    remaining_next = remaining - CNT_ONE;
                end else begin
                    go             = 1'b1;
                    phase_next     = phase + 3'd1;
                    remaining_next = entry_load(phase + 3'd1, ctrl == PREEMPT, left_ok_n, left_ok_e);
                end
            end

            // An advance in the same cycle wins; the emergency is judged against the new phase next cycle.
            case (ctrl)
                RUN: begin
                    if (esync && !go) begin
                        if (is_red(phase)) begin
                            ctrl_next = HOLD;
                        end else begin
                            ctrl_next = PREEMPT;
                            if (is_trunc(phase)) begin
                                remaining_next = '0;
                            end
                        end
                    end
                end
                PREEMPT: begin
                    if (go && is_red(phase_next)) begin
                        ctrl_next = HOLD;
                    end
                end
                HOLD: begin
                    if (!esync) begin
                        ctrl_next = RUN;
                    end
                end
                default: ctrl_next = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized self-checking bench for phase_sequencer against a per-phase elapsed-time model.
module tb_phase_sequencer;

    localparam int D  = 4;
    localparam int G  = 3;
    localparam int Y  = 2;
    localparam int R  = 1;
    localparam int L  = 2;
    localparam int CW = 8;

    logic clk       = 1'b0;
    logic resetn    = 1'b0;
    logic enable    = 1'b0;
    logic emergency = 1'b0;
`ifdef PHASE_SEQ_LEFT_SENSE_EN
    logic left_req_n = 1'b0;
    logic left_req_e = 1'b0;
`endif
    logic          go;
    logic [2:0]    phase;
    logic [CW-1:0] remaining;
    logic          emerg_active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: current phase, enabled cycles spent in it, its tick budget, mode 0 run / 1 preempt / 2 hold.
    int m_phase, m_e, m_budget, m_mode;
    bit m_s1, m_s2, m_ln, m_le;

    phase_sequencer #(
        .CLK_DIV(D), .GREEN_T(G), .YELLOW_T(Y), .RED_T(R), .LEFT_T(L), .CNT_W(CW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .emergency   (emergency),
`ifdef PHASE_SEQ_LEFT_SENSE_EN
        .left_req_n  (left_req_n),
        .left_req_e  (left_req_e),
`endif
        .go          (go),
        .phase       (phase),
        .remaining   (remaining),
        .emerg_active(emerg_active)
    );

    always #5 clk = ~clk;

    function automatic int dur_ticks(input int p);
        case (p)
            0, 4:    return G;
            1, 5:    return Y;
            2, 6:    return R;
            default: return L;
        endcase
    endfunction

    function automatic bit red_phase(input int p);
        return (p == 2) || (p == 6);
    endfunction

    function automatic bit cut_phase(input int p);
        return (p == 0) || (p == 3) || (p == 4) || (p == 7);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_e = 0; m_budget = G; m_mode = 0;
        m_s1 = 0; m_s2 = 0; m_ln = 0; m_le = 0;
    endtask

    function automatic bit model_go();
        return resetn && enable && (m_mode != 2) && (m_e == m_budget * D - 1);
    endfunction

    task automatic model_update();
        bit go_now;
        bit es;
        bit ok_left;
        int op;
        int np;
        if (!resetn) begin
            model_reset();
            return;
        end
        go_now  = model_go();
        es      = m_s2;
        op      = m_phase;
        np      = (m_phase + 1) % 8;
        ok_left = 1;
`ifdef PHASE_SEQ_LEFT_SENSE_EN
        if (np == 3) ok_left = m_le | left_req_e;
        if (np == 7) ok_left = m_ln | left_req_n;
`endif
        if (enable) begin
            if (m_mode == 2) begin
                m_e = (m_e / D) * D;
                if (!es) m_mode = 0;
            end else if (go_now) begin
                if ((m_mode == 1 && cut_phase(np)) || !ok_left) m_budget = 1;
                else m_budget = dur_ticks(np);
                if (m_mode == 1 && red_phase(np)) m_mode = 2;
                m_phase = np;
                m_e     = 0;
            end else begin
                m_e = m_e + 1;
                if (m_mode == 0 && es) begin
                    if (red_phase(m_phase)) m_mode = 2;
                    else begin
                        m_mode = 1;
                        if (cut_phase(m_phase)) m_budget = m_e / D + 1;
                    end
                end
            end
        end
`ifdef PHASE_SEQ_LEFT_SENSE_EN
        if (left_req_e && op != 3) m_le = 1;
        else if (go_now && op == 3) m_le = 0;
        if (left_req_n && op != 7) m_ln = 1;
        else if (go_now && op == 7) m_ln = 0;
`else
        if (go_now && op > 7) m_ln = 0;
`endif
        m_s2 = m_s1;
        m_s1 = emergency;
    endtask

    // One clock: compare the DUT against the model, then advance both across a rising edge.
    task automatic step();
        bit exp_g;
        int exp_rem;
        #1;
        exp_g   = model_go();
        exp_rem = m_budget - 1 - m_e / D;
        checks++;
        if (go !== exp_g) begin
            errors++;
            $display("[TB] FAIL go cyc=%0d actual=%b expected=%b", cyc, go, exp_g);
        end
        checks++;
        if (phase !== 3'(m_phase)) begin
            errors++;
            $display("[TB] FAIL phase cyc=%0d actual=%0d expected=%0d", cyc, phase, m_phase);
        end
        checks++;
        if (remaining !== CW'(exp_rem)) begin
            errors++;
            $display("[TB] FAIL remaining cyc=%0d actual=%0d expected=%0d", cyc, remaining, exp_rem);
        end
        checks++;
        if (emerg_active !== (m_mode != 0)) begin
            errors++;
            $display("[TB] FAIL emerg_active cyc=%0d actual=%b expected=%b", cyc, emerg_active, m_mode != 0);
        end
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_phase(input int p, input int limit, output int n);
        n = 0;
        while (phase !== 3'(p) && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (phase !== 3'(p)) begin
            errors++;
            $display("[TB] FAIL wait_phase%0d timeout actual=%0d required=%0d", p, phase, p);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        emergency = 1'b0;
        model_reset();
        step();
        step();
        resetn = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        do_reset();
        repeat (5) step();
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (go !== 1'b0 || phase !== 3'd0 || remaining !== CW'(G - 1) || emerg_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values actual=%b/%0d/%0d/%b required=0/0/%0d/0",
                     go, phase, remaining, emerg_active, G - 1);
        end
        model_reset();
        @(negedge clk);
        step();
        resetn = 1'b1;
        cyc = 0;
    endtask

    task automatic test_timing();
        int edges[$];
`ifdef PHASE_SEQ_LEFT_SENSE_EN
        int gaps[8] = '{8, 4, 4, 12, 8, 4, 4, 12};
`else
        int gaps[8] = '{8, 4, 8, 12, 8, 4, 8, 12};
`endif
        enable = 1'b1;
        do_reset();
        for (int i = 0; i < 150 && edges.size() < 9; i++) begin
            if (go === 1'b1) edges.push_back(cyc + 1);
            step();
        end
        checks++;
        if (edges.size() != 9) begin
            errors++;
            $display("[TB] FAIL go_count actual=%0d required=9", edges.size());
        end else begin
            checks++;
            if (edges[0] != 12) begin
                errors++;
                $display("[TB] FAIL first_go_edge actual=%0d required=12", edges[0]);
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (edges[k + 1] - edges[k] != gaps[k]) begin
                    errors++;
                    $display("[TB] FAIL go_gap%0d actual=%0d required=%0d", k, edges[k + 1] - edges[k], gaps[k]);
                end
            end
        end
    endtask

    task automatic test_enable();
        int n;
        int entry;
        wait_phase(4, 100, n);
        entry = cyc;
        repeat (3) step();
        enable = 1'b0;
        repeat (10) step();
        enable = 1'b1;
        wait_phase(5, 40, n);
        checks++;
        if (cyc - entry != G * D + 10) begin
            errors++;
            $display("[TB] FAIL enable_stretch actual=%0d required=%0d", cyc - entry, G * D + 10);
        end
    endtask

    task automatic test_emergency_green();
        int n;
        enable = 1'b1;
        do_reset();
        step();
        emergency = 1'b1;
        wait_phase(1, 20, n);
        wait_phase(2, 20, n);
        checks++;
        if (n != Y * D) begin
            errors++;
            $display("[TB] FAIL preempt_yellow_len actual=%0d required=%0d", n, Y * D);
        end
        repeat (100) step();
        checks++;
        if (phase !== 3'd2 || emerg_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_red actual=%0d/%b required=2/1", phase, emerg_active);
        end
        emergency = 1'b0;
        wait_phase(3, 20, n);
        checks++;
        if (emerg_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_emerg actual=%b required=0", emerg_active);
        end
    endtask

    task automatic test_emergency_left();
        int n;
        emergency = 1'b1;
        wait_phase(4, 20, n);
        wait_phase(5, 20, n);
        checks++;
        if (n != D) begin
            errors++;
            $display("[TB] FAIL truncated_green_len actual=%0d required=%0d", n, D);
        end
        wait_phase(6, 20, n);
        checks++;
        if (n != Y * D) begin
            errors++;
            $display("[TB] FAIL full_yellow_len actual=%0d required=%0d", n, Y * D);
        end
        repeat (20) step();
        checks++;
        if (phase !== 3'd6 || emerg_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_red2 actual=%0d/%b required=6/1", phase, emerg_active);
        end
        emergency = 1'b0;
        wait_phase(7, 20, n);
    endtask

    task automatic test_emergency_red();
        int n;
        wait_phase(6, 100, n);
        emergency = 1'b1;
        repeat (30) step();
        checks++;
        if (phase !== 3'd6 || remaining !== CW'(R - 1) || emerg_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL red_hold actual=%0d/%0d/%b required=6/%0d/1", phase, remaining, emerg_active, R - 1);
        end
        emergency = 1'b0;
        wait_phase(7, 20, n);
    endtask

    task automatic test_async_reset();
        int n;
        wait_phase(4, 100, n);
        emergency = 1'b1;
        wait_phase(5, 20, n);
        repeat (2) step();
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (go !== 1'b0 || phase !== 3'd0 || remaining !== CW'(G - 1) || emerg_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midphase_reset actual=%b/%0d/%0d/%b required=0/0/%0d/0",
                     go, phase, remaining, emerg_active, G - 1);
        end
        model_reset();
        emergency = 1'b0;
        @(negedge clk);
        step();
        resetn = 1'b1;
        cyc = 0;
        repeat (6) step();
    endtask

    task automatic test_back_to_back();
        enable = 1'b1;
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) emergency = ~emergency;
`ifdef PHASE_SEQ_LEFT_SENSE_EN
            left_req_n = ($urandom_range(0, 29) == 0);
            left_req_e = ($urandom_range(0, 29) == 0);
`endif
            step();
        end
        enable = 1'b1;
        emergency = 1'b0;
`ifdef PHASE_SEQ_LEFT_SENSE_EN
        left_req_n = 1'b0;
        left_req_e = 1'b0;
`endif
        repeat (20) step();
    endtask

`ifdef PHASE_SEQ_LEFT_SENSE_EN
    task automatic test_left_sense();
        int n;
        enable = 1'b1;
        do_reset();
        wait_phase(3, 60, n);
        wait_phase(4, 20, n);
        checks++;
        if (n != D) begin
            errors++;
            $display("[TB] FAIL left_idle_len actual=%0d required=%0d", n, D);
        end
        do_reset();
        step();
        left_req_e = 1'b1;
        step();
        left_req_e = 1'b0;
        wait_phase(3, 60, n);
        wait_phase(4, 20, n);
        checks++;
        if (n != L * D) begin
            errors++;
            $display("[TB] FAIL left_demand_len actual=%0d required=%0d", n, L * D);
        end
    endtask
`endif

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_timing();
        test_enable();
        test_emergency_green();
        test_emergency_left();
        test_emergency_red();
        test_async_reset();
`ifdef PHASE_SEQ_LEFT_SENSE_EN
        test_left_sense();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
